dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 159 +++++++++++++++
 tb/tb_dmem_responder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte-lane writes plus a four-register MMIO window
// (TOHOST, WRITE_COUNT, ERR_STATUS, CYCLE_COUNT) used to end and diagnose test programs.
module dmem_responder #(
  parameter int unsigned MEM_SIZE_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE      = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] d_mem_addr,
  input  logic [31:0] d_mem_wdata,
  input  logic [3:0]  d_mem_wen,
  output logic [31:0] d_mem_rdata,
  output logic        done,
  output logic [31:0] done_code,
  output logic        err
);

  localparam int unsigned AW        = $clog2(MEM_SIZE_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_SIZE_WORDS);
  localparam logic [1:0]  REG_TOHOST = 2'd0;
  localparam logic [1:0]  REG_WCOUNT = 2'd1;
  localparam logic [1:0]  REG_ERR    = 2'd2;
  localparam logic [1:0]  REG_CCOUNT = 2'd3;

  logic [31:0]   mem [MEM_SIZE_WORDS];
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_word;
  logic [31:0]   merged_word;
  logic [31:0]   mmio_off;
  logic [1:0]    reg_sel;
  logic          in_ram;
  logic          in_mmio;
  logic          wen_any;
  logic          wen_legal;
  logic          ram_we;

  logic        done_reg, done_next;
  logic [31:0] done_code_reg, done_code_next;
  logic [31:0] write_count_reg, write_count_next;
  logic [31:0] cycle_count_reg, cycle_count_next;
  logic [3:0]  err_status_reg, err_status_next;
  logic [3:0]  err_set;
  logic [3:0]  err_clr;

  // Address decode; word index aliases outside the RAM but writes there are gated by in_ram.
  assign ram_idx  = d_mem_addr[AW+1:2];
  assign ram_word = mem[ram_idx];
  assign mmio_off = d_mem_addr - MMIO_BASE;
  assign in_ram   = d_mem_addr < RAM_BYTES;
  assign in_mmio  = (d_mem_addr >= MMIO_BASE) && (mmio_off < 32'd16);
  assign reg_sel  = mmio_off[3:2];
  assign wen_any  = |d_mem_wen;

  always_comb begin
    wen_legal = 1'b0;
    case (d_mem_wen)
      4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: wen_legal = 1'b1;
      default:                            wen_legal = 1'b0;
    endcase
  end

  assign ram_we = wen_legal && in_ram;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = d_mem_wen[gi] ? d_mem_wdata[8*gi +: 8] : ram_word[8*gi +: 8];
    end
  endgenerate

  // RAM is never reset; writes while reset is held are dropped.
  always_ff @(posedge clk) begin
    if (rst_n && ram_we) begin
      mem[ram_idx] <= merged_word;
    end
  end

  always_comb begin
    done_next        = done_reg;
    done_code_next   = done_code_reg;
    write_count_next = write_count_reg;
    cycle_count_next = cycle_count_reg;
    err_set          = 4'b0000;
    err_clr          = 4'b0000;

    if (!done_reg && (cycle_count_reg != 32'hFFFF_FFFF)) begin
      cycle_count_next = cycle_count_reg + 32'd1;
    end

    if (wen_any && !wen_legal) begin
      err_set[1] = 1'b1;
    end else if (wen_legal) begin
      if (in_ram) begin
        if (write_count_reg != 32'hFFFF_FFFF) begin
          write_count_next = write_count_reg + 32'd1;
        end
      end else if (in_mmio) begin
        case (reg_sel)
          REG_TOHOST: begin
            if (d_mem_wen == 4'b1111) begin
              if (!done_reg) begin
                done_next      = 1'b1;
                done_code_next = d_mem_wdata;
              end
            end else begin
              err_set[3] = 1'b1;
            end
          end
          REG_WCOUNT, REG_CCOUNT: err_set[2] = 1'b1;
          default: begin
            if (d_mem_wen == 4'b1111) begin
              err_clr = d_mem_wdata[3:0];
            end
          end
        endcase
      end else begin
        err_set[0] = 1'b1;
      end
    end

    // Set dominates a simultaneous write-one-to-clear.
    err_status_next = (err_status_reg & ~err_clr) | err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_reg        <= 1'b0;
      done_code_reg   <= 32'd0;
      write_count_reg <= 32'd0;
      cycle_count_reg <= 32'd0;
      err_status_reg  <= 4'b0000;
    end else begin
      done_reg        <= done_next;
      done_code_reg   <= done_code_next;
      write_count_reg <= write_count_next;
      cycle_count_reg <= cycle_count_next;
      err_status_reg  <= err_status_next;
    end
  end

  always_comb begin
    d_mem_rdata = 32'hDEAD_BEEF;
    if (in_ram) begin
      d_mem_rdata = ram_word;
    end else if (in_mmio) begin
      case (reg_sel)
        REG_TOHOST: d_mem_rdata = done_code_reg;
        REG_WCOUNT: d_mem_rdata = write_count_reg;
        REG_ERR:    d_mem_rdata = {28'd0, err_status_reg};
        default:    d_mem_rdata = cycle_count_reg;
      endcase
    end
  end

  assign done      = done_reg;
  assign done_code = done_code_reg;
  assign err       = |err_status_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vectors plus randomized traffic
// compared against a rule-level memory/MMIO model.
module tb_dmem_responder;

  localparam int          WORDS = 1024;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] d_mem_addr = 32'd0;
  logic [31:0] d_mem_wdata = 32'd0;
  logic [3:0]  d_mem_wen = 4'd0;
  logic [31:0] d_mem_rdata;
  logic        done;
  logic [31:0] done_code;
  logic        err;

  dmem_responder #(
    .MEM_SIZE_WORDS(WORDS),
    .MMIO_BASE     (BASE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_mem_addr (d_mem_addr),
    .d_mem_wdata(d_mem_wdata),
    .d_mem_wen  (d_mem_wen),
    .d_mem_rdata(d_mem_rdata),
    .done       (done),
    .done_code  (done_code),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] m_mem [WORDS];
  bit          m_valid [WORDS];
  bit          m_done;
  logic [31:0] m_code;
  logic [31:0] m_wc;
  logic [31:0] m_cc;
  logic [3:0]  m_err;

  function automatic bit legal_wen(input logic [3:0] w);
    return w inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  endfunction

  function automatic bit is_ram(input logic [31:0] a);
    return a < 32'(4 * WORDS);
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'd16);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    r = 32'hDEAD_BEEF;
    if (is_ram(a)) begin
      r = m_mem[a >> 2];
    end else if (is_mmio(a)) begin
      case ((a - BASE) >> 2)
        32'd0:   r = m_code;
        32'd1:   r = m_wc;
        32'd2:   r = {28'd0, m_err};
        default: r = m_cc;
      endcase
    end
    return r;
  endfunction

  function automatic bit model_known(input logic [31:0] a);
    if (is_ram(a)) return m_valid[a >> 2];
    return 1'b1;
  endfunction

  task automatic model_update(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    logic [31:0] off;
    if (!m_done && (m_cc != 32'hFFFF_FFFF)) m_cc = m_cc + 32'd1;
    if (w == 4'd0) return;
    if (!legal_wen(w)) begin
      m_err[1] = 1'b1;
      return;
    end
    if (is_ram(a)) begin
      for (int l = 0; l < 4; l++) begin
        if (w[l]) m_mem[a >> 2][8*l +: 8] = d[8*l +: 8];
      end
      if (w == 4'b1111) m_valid[a >> 2] = 1'b1;
      if (m_wc != 32'hFFFF_FFFF) m_wc = m_wc + 32'd1;
    end else if (is_mmio(a)) begin
      off = (a - BASE) >> 2;
      if (off == 32'd0) begin
        if (w != 4'b1111) m_err[3] = 1'b1;
        else if (!m_done) begin
          m_done = 1'b1;
          m_code = d;
        end
      end else if (off == 32'd2) begin
        if (w == 4'b1111) m_err = m_err & ~d[3:0];
      end else begin
        m_err[2] = 1'b1;
      end
    end else begin
      m_err[0] = 1'b1;
    end
  endtask

  // One bus transaction: drive, check combinational read (old value), clock, check outputs.
  task automatic do_cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    logic [31:0] exp_rd;
    d_mem_addr  = a;
    d_mem_wdata = d;
    d_mem_wen   = w;
    #1;
    exp_rd = model_read(a);
    $display("txn addr=%08h wdata=%08h wen=%04b rdata=%08h done=%0b err=%0b",
             a, d, w, d_mem_rdata, done, err);
    if (model_known(a)) begin
      n_cmp++;
      if (d_mem_rdata !== exp_rd) begin
        n_fail++;
        $display("FAIL rdata addr=%08h got=%08h exp=%08h", a, d_mem_rdata, exp_rd);
      end
    end
    @(posedge clk);
    model_update(a, d, w);
    #1;
    n_cmp++;
    if (done !== m_done) begin
      n_fail++;
      $display("FAIL done got=%0b exp=%0b", done, m_done);
    end
    n_cmp++;
    if (done_code !== m_code) begin
      n_fail++;
      $display("FAIL done_code got=%08h exp=%08h", done_code, m_code);
    end
    n_cmp++;
    if (err !== (|m_err)) begin
      n_fail++;
      $display("FAIL err got=%0b exp=%0b", err, |m_err);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    d_mem_wen  = 4'd0;
    d_mem_addr = BASE + 32'd4;
    #1;
    n_cmp++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%0b exp=0", done); end
    n_cmp++;
    if (done_code !== 32'd0) begin n_fail++; $display("FAIL rst_done_code got=%08h exp=0", done_code); end
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%0b exp=0", err); end
    n_cmp++;
    if (d_mem_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_write_count got=%08h exp=0", d_mem_rdata); end
    d_mem_addr = BASE + 32'd12;
    #1;
    n_cmp++;
    if (d_mem_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_cycle_count got=%08h exp=0", d_mem_rdata); end
    // A write held across an edge during reset must be discarded.
    d_mem_addr  = 32'h100;
    d_mem_wdata = 32'hFFFF_FFFF;
    d_mem_wen   = 4'b1111;
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL rst_hold_done got=%0b exp=0", done); end
    @(negedge clk);
    d_mem_wen = 4'd0;
    rst_n     = 1'b1;
    m_done = 1'b0;
    m_code = 32'd0;
    m_wc   = 32'd0;
    m_cc   = 32'd0;
    m_err  = 4'd0;
    $display("txn reset pulse complete");
  endtask

  task automatic test_reset();
    #2;
    pulse_reset();
    do_cycle(BASE + 32'd4, 32'd0, 4'd0);
    do_cycle(BASE + 32'd12, 32'd0, 4'd0);
    do_cycle(BASE + 32'd12, 32'd0, 4'd0);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 128; i++) do_cycle(32'(i * 4), $urandom, 4'b1111);
  endtask

  task automatic test_spec_vectors();
    logic [31:0] exp0;
    pulse_reset();
    do_cycle(32'h100, 32'h0000_0003, 4'b1111);
    do_cycle(32'h100, 32'h0000_AB00, 4'b0010);
    do_cycle(32'h100, 32'd0, 4'd0);
    n_cmp++;
    if (d_mem_rdata !== 32'h0000_AB03) begin n_fail++; $display("FAIL lane_merge got=%08h exp=0000ab03", d_mem_rdata); end
    do_cycle(BASE + 32'd4, 32'd0, 4'd0);
    n_cmp++;
    if (d_mem_rdata !== 32'd2) begin n_fail++; $display("FAIL write_count got=%08h exp=00000002", d_mem_rdata); end

    do_cycle(32'h104, 32'hFFFF_FFFF, 4'b0110);
    do_cycle(32'h104, 32'd0, 4'd0);
    n_cmp++;
    if (d_mem_rdata !== m_mem[65]) begin n_fail++; $display("FAIL illegal_wen_ram got=%08h exp=%08h", d_mem_rdata, m_mem[65]); end
    do_cycle(BASE + 32'd8, 32'd0, 4'd0);
    n_cmp++;
    if (d_mem_rdata !== 32'd2 || err !== 1'b1) begin n_fail++; $display("FAIL illegal_wen_err got=%08h/%0b exp=00000002/1", d_mem_rdata, err); end
    do_cycle(BASE + 32'd8, 32'd2, 4'b1111);
    do_cycle(BASE + 32'd8, 32'd0, 4'd0);
    n_cmp++;
    if (d_mem_rdata !== 32'd0 || err !== 1'b0) begin n_fail++; $display("FAIL w1c_clear got=%08h/%0b exp=00000000/0", d_mem_rdata, err); end

    exp0 = m_mem[0];
    do_cycle(32'h2000, 32'h5555_AAAA, 4'b1111);
    do_cycle(32'h2000, 32'd0, 4'd0);
    n_cmp++;
    if (d_mem_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL oor_read got=%08h exp=deadbeef", d_mem_rdata); end
    do_cycle(32'h0, 32'd0, 4'd0);
    n_cmp++;
    if (d_mem_rdata !== exp0) begin n_fail++; $display("FAIL oor_alias got=%08h exp=%08h", d_mem_rdata, exp0); end
    do_cycle(BASE + 32'd8, 32'd0, 4'd0);
    n_cmp++;
    if (d_mem_rdata !== 32'd1) begin n_fail++; $display("FAIL oor_err got=%08h exp=00000001", d_mem_rdata); end
    do_cycle(BASE + 32'd8, 32'd1, 4'b1111);
  endtask

  task automatic test_ro_write();
    logic [31:0] wc_before;
    wc_before = m_wc;
    do_cycle(BASE + 32'd4, $urandom, 4'b1111);
    do_cycle(BASE + 32'd12, $urandom, 4'b1111);
    do_cycle(BASE + 32'd4, 32'd0, 4'd0);
    n_cmp++;
    if (d_mem_rdata !== wc_before) begin n_fail++; $display("FAIL ro_write_count got=%08h exp=%08h", d_mem_rdata, wc_before); end
    do_cycle(BASE + 32'd8, 32'd0, 4'd0);
    n_cmp++;
    if (d_mem_rdata[2] !== 1'b1) begin n_fail++; $display("FAIL ro_err_bit2 got=%0b exp=1", d_mem_rdata[2]); end
    do_cycle(BASE + 32'd8, 32'hF, 4'b1111);
    do_cycle(BASE + 32'd8, 32'd0, 4'd0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [3:0]  w;
    int          kind;
    for (int i = 0; i < 400; i++) begin
      kind = int'($urandom_range(0, 9));
      w    = 4'($urandom_range(0, 15));
      if (kind <= 5) begin
        a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      end else if (kind == 6) begin
        a = BASE + (32'($urandom_range(1, 3)) << 2);
      end else if (kind == 7) begin
        a = BASE;
        w = 4'($urandom_range(0, 14));
      end else if (kind == 8) begin
        a = 32'h2000 + (32'($urandom_range(0, 255)) << 2);
      end else begin
        a = (32'($urandom_range(0, 63)) << 2);
        w = 4'd0;
      end
      do_cycle(a, $urandom, w);
    end
  endtask

  task automatic test_tohost();
    logic [31:0] cc_frozen;
    do_cycle(BASE, 32'h0000_0001, 4'b1111);
    n_cmp++;
    if (done !== 1'b1 || done_code !== 32'd1) begin n_fail++; $display("FAIL tohost_first got=%0b/%08h exp=1/00000001", done, done_code); end
    do_cycle(BASE, 32'h0000_0BAD, 4'b1111);
    n_cmp++;
    if (done_code !== 32'd1) begin n_fail++; $display("FAIL tohost_second got=%08h exp=00000001", done_code); end
    do_cycle(BASE, 32'd0, 4'd0);
    n_cmp++;
    if (d_mem_rdata !== 32'd1) begin n_fail++; $display("FAIL tohost_read got=%08h exp=00000001", d_mem_rdata); end
    cc_frozen = m_cc;
    for (int i = 0; i < 3; i++) begin
      do_cycle(BASE + 32'd12, 32'd0, 4'd0);
      n_cmp++;
      if (d_mem_rdata !== cc_frozen) begin n_fail++; $display("FAIL cycle_frozen got=%08h exp=%08h", d_mem_rdata, cc_frozen); end
    end
  endtask

  task automatic test_reset_after_done();
    pulse_reset();
    do_cycle(32'h100, 32'd0, 4'd0);
    n_cmp++;
    if (d_mem_rdata !== 32'h0000_AB03) begin n_fail++; $display("FAIL ram_retained got=%08h exp=0000ab03", d_mem_rdata); end
    do_cycle(BASE + 32'd12, 32'd0, 4'd0);
    do_cycle(BASE + 32'd12, 32'd0, 4'd0);
    n_cmp++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_after_reset got=%0b exp=0", done); end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      m_mem[i]   = 32'd0;
      m_valid[i] = 1'b0;
    end
    m_done = 1'b0;
    m_code = 32'd0;
    m_wc   = 32'd0;
    m_cc   = 32'd0;
    m_err  = 4'd0;
    test_reset();
    test_fill();
    test_spec_vectors();
    test_ro_write();
    test_random();
    test_tohost();
    test_reset_after_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
